// File: rtl/debounce_scan_scheduler.sv
// debounce_scan_scheduler
//   Debounce controller for all board push-buttons on one shared timebase.
//   A free-running tick counter starts a round-robin scan; each scan visits
//   every switch for one clock and runs that switch's stability counter.
//   Debounced levels are output directly, and press/release edges are queued
//   in a first-word-fall-through event FIFO with a valid/ready handshake.
//
// Optional build macro: DEBOUNCE_LONG_PRESS_EN
//   Adds a per-switch hold counter. A type-10 (long press) event is queued
//   once after c_LONG_TICKS scan slots with the debounced level held at 1.
//
// Ports
//   i_Clk             system clock
//   i_Rst_L           synchronous active-low reset
//   i_Switch          raw asynchronous switch levels (1 = pressed)
//   o_Switch          debounced switch levels
//   o_Event_Valid     event queue non-empty
//   i_Event_Ready     consumer accepts the head event
//   o_Event_Id        switch index of the head event
//   o_Event_Type      00 release, 01 press, 10 long press
//   o_Overflow        sticky flag: an event was dropped on a full queue
//   i_Clear_Overflow  clears o_Overflow (a same-cycle drop wins)

module debounce_scan_scheduler #(
    parameter int NUM_SWITCHES   = 4,
    parameter int c_TICK_LIMIT   = 25000,
    parameter int c_STABLE_TICKS = 10,
    parameter int c_FIFO_DEPTH   = 4,
    parameter int c_LONG_TICKS   = 1000,
    localparam int ID_W          = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic                    o_Event_Valid,
    input  logic                    i_Event_Ready,
    output logic [ID_W-1:0]         o_Event_Id,
    output logic [1:0]              o_Event_Type,
    output logic                    o_Overflow,
    input  logic                    i_Clear_Overflow
);

    localparam int TICK_W = (c_TICK_LIMIT > 1) ? $clog2(c_TICK_LIMIT) : 1;
    localparam int CNT_W  = $clog2(c_STABLE_TICKS + 1);
    localparam int PTR_W  = $clog2(c_FIFO_DEPTH);

    typedef enum logic {
        S_WAIT,
        S_SCAN
    } state_t;

    logic [NUM_SWITCHES-1:0] sync1;
    logic [NUM_SWITCHES-1:0] sync2;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    state_t                  state;
    logic [ID_W-1:0]         scan_idx;
    logic [CNT_W-1:0]        stab_cnt [NUM_SWITCHES];

    logic                    sample;
    logic                    cur_level;
    logic                    toggle;
    logic                    push_req;
    logic [1:0]              push_type;

    logic [ID_W+1:0]         fifo_mem [c_FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr;
    logic [PTR_W:0]          rd_ptr;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    do_pop;
    logic                    do_push;
    logic                    do_drop;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(c_LONG_TICKS + 1);
    logic [HOLD_W-1:0]       hold_cnt [NUM_SWITCHES];
    logic                    long_hit;
`else
    // c_LONG_TICKS has no effect in this build.
    logic                    unused_long_ticks;
    assign unused_long_ticks = (c_LONG_TICKS != 0);
`endif

    assign tick = (tick_cnt == TICK_W'(c_TICK_LIMIT - 1));

    // Slot evaluation for the switch currently addressed by the scan.
    always_comb begin
        sample    = sync2[scan_idx];
        cur_level = o_Switch[scan_idx];
        toggle    = (state == S_SCAN) && (sample != cur_level) &&
                    (stab_cnt[scan_idx] == CNT_W'(c_STABLE_TICKS - 1));
        push_req  = toggle;
        push_type = {1'b0, sample};
`ifdef DEBOUNCE_LONG_PRESS_EN
        long_hit  = (state == S_SCAN) && cur_level &&
                    (hold_cnt[scan_idx] == HOLD_W'(c_LONG_TICKS - 1));
        // A toggle on the same slot takes the push; the long event is lost.
        if (long_hit && !toggle) begin
            push_req  = 1'b1;
            push_type = 2'b10;
        end
`endif
    end

    // FIFO flags and handshake; a full-queue push succeeds if a pop frees a slot.
    always_comb begin
        fifo_empty    = (wr_ptr == rd_ptr);
        fifo_full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        do_pop        = !fifo_empty && i_Event_Ready;
        do_push       = push_req && (!fifo_full || do_pop);
        do_drop       = push_req && fifo_full && !do_pop;
        o_Event_Valid = !fifo_empty;
        {o_Event_Id, o_Event_Type} = fifo_mem[rd_ptr[PTR_W-1:0]];
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1      <= '0;
            sync2      <= '0;
            tick_cnt   <= '0;
            state      <= S_WAIT;
            scan_idx   <= '0;
            o_Switch   <= '0;
            o_Overflow <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
                stab_cnt[i] <= '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
                hold_cnt[i] <= '0;
`endif
            end
            for (int unsigned j = 0; j < c_FIFO_DEPTH; j++) begin
                fifo_mem[j] <= '0;
            end
        end else begin
            sync1    <= i_Switch;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            case (state)
                S_WAIT: begin
                    if (tick) begin
                        state    <= S_SCAN;
                        scan_idx <= '0;
                    end
                end
                S_SCAN: begin
                    if (sample == cur_level) begin
                        stab_cnt[scan_idx] <= '0;
                    end else if (toggle) begin
                        o_Switch[scan_idx] <= sample;
                        stab_cnt[scan_idx] <= '0;
                    end else begin
                        stab_cnt[scan_idx] <= stab_cnt[scan_idx] + 1'b1;
                    end
`ifdef DEBOUNCE_LONG_PRESS_EN
                    // Hold count saturates at c_LONG_TICKS, so the long event fires once.
                    if (toggle && cur_level) begin
                        hold_cnt[scan_idx] <= '0;
                    end else if (cur_level &&
                                 hold_cnt[scan_idx] < HOLD_W'(c_LONG_TICKS)) begin
                        hold_cnt[scan_idx] <= hold_cnt[scan_idx] + 1'b1;
                    end
`endif
                    if (scan_idx == ID_W'(NUM_SWITCHES - 1)) begin
                        state <= S_WAIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase

            if (do_push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= {scan_idx, push_type};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (do_drop) begin
                o_Overflow <= 1'b1;
            end else if (i_Clear_Overflow) begin
                o_Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/debounce_scan_scheduler.md
Name: debounce_scan_scheduler

Overview:
- Shared-timebase debounce controller for all board push-buttons.
- One free-running tick counter drives a round-robin scheduler. The scheduler visits each switch once per tick and runs that switch's stability counter, so there is no per-switch 10 ms counter.
- Emits debounced levels plus a queued press/release event stream, with valid/ready handshake, for downstream UI logic (LED, 7-seg and game FSMs).

Parameters:
- NUM_SWITCHES, 4, number of switch inputs scanned (1..8).
- c_TICK_LIMIT, 25000, clocks per scan tick (1 ms at 25 MHz); must be >= NUM_SWITCHES+1.
- c_STABLE_TICKS, 10, consecutive differing scan samples required before the debounced level toggles (>=1).
- c_FIFO_DEPTH, 4, event queue entries (power of 2, >=2).
- c_LONG_TICKS, 1000, hold duration in ticks for a long-press event (used only with the optional feature).

Ports:
- i_Clk, input, 1, system clock.
- i_Rst_L, input, 1, synchronous active-low reset.
- i_Switch, input, NUM_SWITCHES, raw asynchronous switch levels (1 = pressed).
- o_Switch, output, NUM_SWITCHES, debounced levels.
- o_Event_Valid, output, 1, event queue non-empty.
- i_Event_Ready, input, 1, consumer accepts the head event.
- o_Event_Id, output, clog2(NUM_SWITCHES) (min 1), switch index of the head event.
- o_Event_Type, output, 2, 00 = release, 01 = press, 10 = long press, 11 = unused.
- o_Overflow, output, 1, sticky: an event was dropped.
- i_Clear_Overflow, input, 1, clears o_Overflow.

Behaviour:
- Reset is synchronous: i_Rst_L sampled low at a clock edge clears all state on that edge. Cleared state is the sync flops, tick counter, FSM (S_WAIT), scan index, all stability and hold counters, and the FIFO (empty).
- Reset values: o_Switch=0, o_Event_Valid=0, o_Event_Id=0, o_Event_Type=00, o_Overflow=0.
- A reset mid-scan abandons the scan. No partial events are queued.
- Input sync: 2-flop synchronizer per bit; only synchronized levels are used.
- Tick counter: counts 0..c_TICK_LIMIT-1 and wraps. The tick is asserted for one clock when the count equals c_TICK_LIMIT-1. The counter is never stalled.
- FSM, S_WAIT: idle. On tick, go to S_SCAN with index=0.
- FSM, S_SCAN: one switch per clock, index 0..NUM_SWITCHES-1. After the last index, return to S_WAIT. A scan lasts exactly NUM_SWITCHES clocks.
- Per-slot rule, sample equals o_Switch[i]: cnt[i] <= 0.
- Per-slot rule, sample differs and cnt[i] == c_STABLE_TICKS-1: o_Switch[i] toggles, cnt[i] <= 0, and a push is requested (type 01 if new level 1, else 00, id=i).
- Per-slot rule, sample differs otherwise: cnt[i] <= cnt[i]+1.
- Latency: a clean edge updates o_Switch after 2 sync clocks plus c_STABLE_TICKS scan slots for that switch. The event is written on the same edge. o_Event_Valid is high from that edge if the queue was empty.
- At most one push per clock, because of the scan. Events from switches changing in the same tick appear in ascending index order.
- FIFO is first-word-fall-through. Head fields are stable while valid && !ready. Pop occurs on valid && ready.
- Full queue: a push is dropped and o_Overflow set, but o_Switch still updates. Push and pop in the same cycle while full are both accepted, and nothing is dropped. Pop on empty is ignored.
- o_Overflow: set on a drop, cleared by i_Clear_Overflow. If set and clear occur in the same cycle, set wins.
- Counters saturate by construction: cnt width is clog2(c_STABLE_TICKS+1). No wrap-around is possible.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined: each switch gets a hold counter that increments on each of its scan slots while o_Switch[i]=1. When it reaches c_LONG_TICKS, one type-10 event is pushed, with the same drop/overflow rules as other events. The counter then holds, so there is no repeat. It clears on release (o_Switch[i] toggling to 0) and on reset.
- Defined, slot priority: if a toggle push and a long push fall on the same slot, the toggle push has priority.
- Undefined: no hold counters are built, type 10 is never produced, and c_LONG_TICKS is ignored.

Test Plan:
All scenarios use c_TICK_LIMIT=8, c_STABLE_TICKS=3, NUM_SWITCHES=4, c_FIFO_DEPTH=4.
1. Reset, then hold i_Switch[2]=1 -> o_Switch[2] rises after exactly 3 scan slots of switch 2; one event id=2, type=01. Release -> id=2, type=00.
2. i_Switch[1] bounces, toggling every 10 clocks for 100 clocks, then rests at 0 -> o_Switch[1] stays 0; no events; o_Overflow=0.
3. i_Switch[0] and i_Switch[3] rise on the same clock -> both update in the same tick; queue order is id=0 then id=3, both type=01.
4. i_Event_Ready=0, generate 5 press/release events -> 4 queued in order, 5th dropped, o_Overflow=1, o_Switch still reflects 5th change. Then pulse i_Clear_Overflow -> o_Overflow=0. Drain with ready=1 -> 4 pops.
5. Assert i_Rst_L=0 for one clock during S_SCAN with cnt[2]=2 -> o_Switch=0, queue empty. The input must then be stable for 3 more slots before o_Switch[2] rises.
6. With DEBOUNCE_LONG_PRESS_EN and c_LONG_TICKS=5, hold i_Switch[1] -> events 01 then, 5 ticks later, 10 (id=1), only once. Release -> 00. Without the macro -> only 01 and 00.
